// File: rtl/gradient_pkg.sv
// Shared types for the animated gradient pattern source: mode encoding and
// the double-buffered configuration record.
package gradient_pkg;

    typedef enum logic [1:0] {
        GM_HORIZ = 2'd0,
        GM_VERT  = 2'd1,
        GM_DIAG  = 2'd2
    } grad_mode_t;

    // Encoding 3 is reserved and behaves as horizontal.
    localparam grad_mode_t GM_FALLBACK = GM_HORIZ;

    // Widest supported scroll-speed field; narrower speed ports are zero-extended.
    localparam int unsigned SPD_W_MAX = 16;

    typedef struct packed {
        logic [1:0]           mode;
        logic [2:0]           tint;
        logic                 invert;
        logic [SPD_W_MAX-1:0] speed;
    } cfg_t;

    function automatic grad_mode_t decode_mode(input logic [1:0] m);
        grad_mode_t r;
        case (m)
            2'd0:    r = GM_HORIZ;
            2'd1:    r = GM_VERT;
            2'd2:    r = GM_DIAG;
            default: r = GM_FALLBACK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Reset-to-zero shift register used as the pixel output stage.
module pix_delay_line #(
    parameter int unsigned W   = 12,
    parameter int unsigned DLY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DLY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DLY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DLY-1];

endmodule

// File: rtl/gradient_anim_src.sv
// Animated gradient pattern source: banded horizontal/vertical/diagonal ramps with
// tint, invert and frame-synchronous scroll; config is applied only at frame start.
module gradient_anim_src
    import gradient_pkg::*;
#(
    parameter int unsigned CD         = 4,
    parameter int unsigned CW         = 11,
    parameter int unsigned STEP_SHIFT = 5,
    parameter int unsigned HLIMIT     = 512,
    parameter int unsigned SPD_W      = 4,
    parameter int unsigned DLY        = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CW-1:0]   x,
    input  logic [CW-1:0]   y,
    input  logic            frame_start,
    input  logic            cfg_wr,
    input  logic [1:0]      mode_in,
    input  logic [2:0]      tint_in,
    input  logic            invert_in,
    input  logic [SPD_W-1:0] speed_in,
    output logic            cfg_pending,
    output logic [3*CD-1:0] gradient_rgb
);

    localparam logic [CW:0] HLIM = (CW+1)'(HLIMIT);

    cfg_t                 shadow_q, shadow_d;
    cfg_t                 active_q, active_d;
    logic                 pending_q, pending_d;
    logic [CD-1:0]        offset_q, offset_d;
    logic [SPD_W_MAX-1:0] fcnt_q, fcnt_d;
    cfg_t                 wr_cfg;

    always_comb begin
        wr_cfg.mode   = mode_in;
        wr_cfg.tint   = tint_in;
        wr_cfg.invert = invert_in;
        wr_cfg.speed  = SPD_W_MAX'(speed_in);
    end

    // Scroll uses the speed active before this edge; a config load then clears
    // fcnt but keeps any offset step taken on the same frame_start.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        offset_d  = offset_q;
        fcnt_d    = fcnt_q;
        if (frame_start) begin
            if (active_q.speed != '0) begin
                if (fcnt_q == active_q.speed - 1'b1) begin
                    fcnt_d   = '0;
                    offset_d = offset_q + 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
                fcnt_d    = '0;
            end
        end
        if (cfg_wr) begin
            shadow_d  = wr_cfg;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            offset_q  <= '0;
            fcnt_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            offset_q  <= offset_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign cfg_pending = pending_q;

    grad_mode_t    mode;
    logic [CW-1:0] raw_h, raw_v;
    logic [CW:0]   diag_sum, raw_d;
    logic [CD-1:0] raw_sel, lvl, base;
    logic          clamp;
    logic [3*CD-1:0] pix;

    always_comb begin
        mode     = decode_mode(active_q.mode);
        raw_h    = x >> STEP_SHIFT;
        raw_v    = y >> STEP_SHIFT;
        diag_sum = {1'b0, x} + {1'b0, y};
        raw_d    = diag_sum >> (STEP_SHIFT + 1);
        raw_sel  = CD'(raw_h);
        clamp    = 1'b0;
        unique case (mode)
            GM_VERT: raw_sel = CD'(raw_v);
            GM_DIAG: raw_sel = CD'(raw_d);
            default: begin
                raw_sel = CD'(raw_h);
                clamp   = ({1'b0, x} >= HLIM);
            end
        endcase
        lvl = raw_sel + offset_q;
        if (active_q.invert) begin
            lvl = ~lvl;
        end
        base = clamp ? {CD{~active_q.invert}} : lvl;
        pix  = {active_q.tint[2] ? {CD{1'b1}} : base,
                active_q.tint[1] ? {CD{1'b1}} : base,
                active_q.tint[0] ? {CD{1'b1}} : base};
    end

    pix_delay_line #(
        .W   (3 * CD),
        .DLY (DLY)
    ) u_out_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pix),
        .dout    (gradient_rgb)
    );

endmodule

// File: tb/tb_gradient_anim_src.sv
// Self-checking bench: expected pixels ride a scoreboard queue DLY cycles deep.
module tb_gradient_anim_src;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x, y;
    logic        frame_start, cfg_wr;
    logic [1:0]  mode_in;
    logic [2:0]  tint_in;
    logic        invert_in;
    logic [3:0]  speed_in;
    logic        cfg_pending;
    logic [11:0] gradient_rgb;

    always #5 clk = ~clk;

    gradient_anim_src dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .cfg_wr       (cfg_wr),
        .mode_in      (mode_in),
        .tint_in      (tint_in),
        .invert_in    (invert_in),
        .speed_in     (speed_in),
        .cfg_pending  (cfg_pending),
        .gradient_rgb (gradient_rgb)
    );

    typedef struct {
        logic        chk;
        logic [11:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  tint;
        logic        inv;
        logic [10:0] px;
        logic [10:0] py;
        logic [11:0] exp;
        string       name;
    } tv_t;

    sb_t sb_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic prime_sb();
        sb_t e;
        sb_q.delete();
        e.chk  = 1'b0;
        e.exp  = '0;
        e.name = "";
        repeat (2) sb_q.push_back(e);
    endtask

    // One clock: sample the output due now, then drive the next inputs.
    task automatic cyc(input logic [10:0] xi, input logic [10:0] yi, input logic fs,
                       input logic wr, input logic [1:0] m, input logic [2:0] t,
                       input logic inv, input logic [3:0] spd, input logic ck,
                       input logic [11:0] ex, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.chk) check(e.name, gradient_rgb, e.exp);
        x = xi; y = yi; frame_start = fs; cfg_wr = wr;
        mode_in = m; tint_in = t; invert_in = inv; speed_in = spd;
        e.chk = ck; e.exp = ex; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic pix(input logic [10:0] xi, input logic [10:0] yi, input logic [11:0] ex,
                       input string nm);
        cyc(xi, yi, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b1, ex, nm);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [2:0] t, input logic inv,
                       input logic [3:0] spd);
        cyc(11'd0, 11'd0, 1'b0, 1'b1, m, t, inv, spd, 1'b0, 12'h0, "");
    endtask

    task automatic fst();
        cyc(11'd0, 11'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b0, 12'h0, "");
    endtask

    tv_t tv [13];

    initial begin
        tv[0]  = '{2'd0, 3'b000, 1'b0,  11'd96,   11'd0, 12'h333, "h_x96"};
        tv[1]  = '{2'd0, 3'b000, 1'b0,  11'd600,  11'd0, 12'hFFF, "h_clamp"};
        tv[2]  = '{2'd0, 3'b001, 1'b0,  11'd96,   11'd0, 12'h33F, "h_tint_b"};
        tv[3]  = '{2'd0, 3'b001, 1'b1,  11'd96,   11'd0, 12'hCCF, "h_tint_inv"};
        tv[4]  = '{2'd0, 3'b001, 1'b1,  11'd600,  11'd0, 12'h00F, "h_clamp_inv"};
        tv[5]  = '{2'd1, 3'b000, 1'b0,  11'd700, 11'd480, 12'hFFF, "v_noclamp"};
        tv[6]  = '{2'd2, 3'b000, 1'b0,  11'd64,  11'd64,  12'h222, "diag_64"};
        tv[7]  = '{2'd2, 3'b000, 1'b0,  11'd200, 11'd200, 12'h666, "diag_200"};
        tv[8]  = '{2'd3, 3'b000, 1'b0,  11'd96,  11'd480, 12'h333, "rsvd_horiz"};
        tv[9]  = '{2'd3, 3'b000, 1'b0,  11'd600, 11'd0,   12'hFFF, "rsvd_clamp"};
        tv[10] = '{2'd1, 3'b000, 1'b1,  11'd900, 11'd32,  12'hEEE, "v_inv"};
        tv[11] = '{2'd0, 3'b110, 1'b0,  11'd64,  11'd0,   12'hFF2, "h_tint_rg"};
        tv[12] = '{2'd1, 3'b100, 1'b0,  11'd0,   11'd96,  12'hF33, "v_tint_r"};

        reset_n = 1'b0;
        x = '0; y = '0; frame_start = 0; cfg_wr = 0;
        mode_in = '0; tint_in = '0; invert_in = 0; speed_in = '0;
        prime_sb();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", gradient_rgb, 12'h000);
        check("reset_pending", cfg_pending, 1'b0);
        reset_n = 1'b1;

        foreach (tv[i]) begin
            cfg(tv[i].mode, tv[i].tint, tv[i].inv, 4'd0);
            fst();
            pix(tv[i].px, tv[i].py, tv[i].exp, tv[i].name);
        end

        // Same-cycle write and frame start, then last-write-wins.
        cfg(2'd0, 3'b000, 1'b0, 4'd0);
        cyc(11'd0, 11'd0, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 4'd0, 1'b0, 12'h0, "");
        pix(11'd96, 11'd480, 12'h333, "same_cyc_old_mode");
        check("same_cyc_pending", cfg_pending, 1'b1);
        fst();
        pix(11'd96, 11'd480, 12'hFFF, "same_cyc_new_mode");
        check("applied_pending", cfg_pending, 1'b0);
        cfg(2'd2, 3'b000, 1'b0, 4'd0);
        cfg(2'd1, 3'b000, 1'b0, 4'd0);
        fst();
        pix(11'd0, 11'd96, 12'h333, "last_write_wins");

        // Scroll at speed 2: four frames after apply give offset 2.
        cfg(2'd0, 3'b000, 1'b0, 4'd2);
        fst();
        repeat (4) fst();
        pix(11'd96,  11'd0, 12'h555, "scroll_x96");
        pix(11'd480, 11'd0, 12'h111, "scroll_wrap");
        pix(11'd511, 11'd0, 12'h111, "scroll_x511");
        pix(11'd512, 11'd0, 12'hFFF, "scroll_x512_clamp");
        cyc(11'd96, 11'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b1, 12'h555, "fs_pix_a");
        cyc(11'd96, 11'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b1, 12'h555, "fs_pix_pre_upd");
        pix(11'd96, 11'd0, 12'h666, "scroll_offset3");
        fst();
        cfg(2'd0, 3'b000, 1'b0, 4'd0);
        fst();
        pix(11'd96, 11'd0, 12'h777, "step_with_load");
        fst();
        fst();
        pix(11'd96, 11'd0, 12'h777, "speed0_frozen_a");
        pix(11'd96, 11'd0, 12'h777, "speed0_frozen_b");
        pix(11'd96, 11'd0, 12'h777, "speed0_frozen_c");
        cfg(2'd1, 3'b000, 1'b0, 4'd0);

        // Mid-frame reset clears output, offset and pending config.
        reset_n = 1'b0;
        #1;
        check("midreset_rgb", gradient_rgb, 12'h000);
        check("midreset_pending", cfg_pending, 1'b0);
        prime_sb();
        @(posedge clk);
        #1;
        check("midreset_rgb_held", gradient_rgb, 12'h000);
        reset_n = 1'b1;
        pix(11'd96, 11'd480, 12'h333, "post_reset_default");
        cfg(2'd0, 3'b000, 1'b0, 4'd0);
        fst();
        pix(11'd96, 11'd0, 12'h333, "post_reset_x96");
        pix(11'd0, 11'd0, 12'h000, "post_reset_x0");

        repeat (2) cyc(11'd0, 11'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b0, 12'h0, "");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gradient_anim_src.md
Name: gradient_anim_src

Overview:
Parametrised, animated successor to the fixed 4-bit gradient pattern source in the video pattern-generator chain. It takes pixel coordinates from the frame timing block and produces a packed RGB pixel through a configurable delay line.
Supported patterns:
- horizontal, vertical and diagonal gradients, each optionally inverted;
- per-channel saturation tint;
- frame-synchronous scrolling at a programmable rate.
Configuration writes are double-buffered and take effect only at frame boundaries, so mode switches never tear mid-frame.

Parameters:
CD, 4, colour depth per channel; output is 3*CD bits.
CW, 11, coordinate width of x/y.
STEP_SHIFT, 5, band width is 2^STEP_SHIFT pixels.
HLIMIT, 512, x at or above this saturates horizontal modes.
SPD_W, 4, width of scroll-speed field.
DLY, 2, output pipeline delay in cycles; must be at least 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
x  in  CW  current pixel column
y  in  CW  current pixel row
frame_start  in  1  one-cycle pulse, at least 1 cycle before pixel (0,0) of each frame
cfg_wr  in  1  strobe; latches mode_in/tint_in/invert_in/speed_in into shadow registers
mode_in  in  2  0=horizontal, 1=vertical, 2=diagonal, 3=reserved (treated as horizontal)
tint_in  in  3  channel saturate mask; bit2=r, bit1=g, bit0=b
invert_in  in  1  invert gradient level
speed_in  in  SPD_W  frames per scroll step; 0 = static
cfg_pending  out  1  shadow config written but not yet applied
gradient_rgb  out  3*CD  {r,g,b} pixel, delayed DLY cycles

Behaviour:
Reset (async assert, sync release):
- active and shadow config: mode 0, tint 0, invert 0, speed 0;
- offset = 0, fcnt = 0, cfg_pending = 0;
- all delay stages and gradient_rgb = 0.

Config handshake:
- On cfg_wr, the shadow config loads and cfg_pending is set to 1.
- On frame_start with cfg_pending=1, active config loads from shadow, cfg_pending clears and fcnt clears.
- cfg_wr and frame_start in the same cycle: frame_start transfers the old shadow; the new write lands in the shadow and cfg_pending stays 1 until the next frame_start.
- Repeated cfg_wr before a frame_start: the last write wins.

Scroll counter:
- Applies on frame_start when the active speed (value before this edge) is nonzero.
- If fcnt == speed-1: fcnt is set to 0 and offset increments by 1 modulo 2^CD.
- Otherwise fcnt increments by 1.
- speed = 0 freezes both fcnt and offset; offset is retained, not cleared.
- The offset increment is still applied when a config load clears fcnt in the same cycle.

Level computation (combinational, from active config):
- Horizontal: raw = x >> STEP_SHIFT.
- Vertical: raw = y >> STEP_SHIFT.
- Diagonal: raw = (x+y) >> (STEP_SHIFT+1), with the sum computed at CW+1 bits.
- lvl = (raw + offset) truncated to CD bits.
- If invert = 1: lvl = ~lvl.

Channel value:
- Tint bit = 1: channel = all ones.
- Tint bit = 0: channel = lvl.
- Horizontal mode with x >= HLIMIT: every non-tinted channel = all ones if invert = 0, all zeros if invert = 1.
- Vertical and diagonal modes have no clamp.

Timing:
- A pixel computed in cycle t appears on gradient_rgb at cycle t+DLY.
- A pixel computed in the same cycle as frame_start uses the pre-update config and offset.

Decomposition:
Package gradient_pkg holds:
- the grad_mode_t enum (GM_HORIZ, GM_VERT, GM_DIAG);
- the cfg_t struct {mode, tint, invert, speed};
- the localparam for the reserved-mode fallback.

Sub-module pix_delay_line, parametrised by width and DLY, provides the reset-to-zero shift-register output stage.

Test Plan:
All scenarios use CD=4, STEP_SHIFT=5, DLY=2.
1. Reset, then cfg_wr with mode=0, tint=0, inv=0, speed=0, then frame_start; x=96 -> 0x333 two cycles later; x=600 -> 0xFFF.
2. Tint=001, horizontal, x=96 -> 0x33F; set invert=1 -> 0xCCF; x=600 with invert=1 -> 0x00F.
3. Mode=1, y=480, x=700 -> 0xFFF (no clamp); mode=2 with x=64, y=64 -> 0x222.
4. Speed=2, horizontal, 4 frame_starts after apply -> offset=2; x=96 -> 0x555; x=480 -> 0x111 (wrap from 17 to 1).
5. cfg_wr (mode=1) and frame_start in the same cycle -> mode stays horizontal and cfg_pending=1; next frame_start -> vertical applied and cfg_pending=0.
6. Assert reset_n=0 mid-frame with offset=3 -> gradient_rgb=0x000 immediately; after release, offset=0 and x=96 -> 0x333 once config is reapplied.
